mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Responder for the CPU-side instruction and data memory handshakes. It produces the `inst_resp` and `data_resp` pulses that the stage sequencer consumes. It arbitrates instruction fetches and data loads/stores onto the single shared physical-memory port, holds each transaction stable until memory answers, and returns read data with a one-cycle response pulse. It sits between the datapath/stage sequencer and the memory model or cache.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, address width for both CPU ports and the memory port.
- `DATA_WIDTH`, 32, data width; byte-enable width is `DATA_WIDTH/8`.
- `MAX_WAIT`, 255, number of cycles spent waiting on `mem_resp` before a transaction is aborted.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset. This is already decided and fixed.
- `inst_read` in 1: fetch request, level, held by the requester until `inst_resp`.
- `inst_addr` in `ADDR_WIDTH`: fetch address.
- `inst_rdata` out `DATA_WIDTH`: registered fetch data, valid while `inst_resp` is high.
- `inst_resp` out 1: one-cycle fetch-complete pulse.
- `data_read`, `data_write` in 1 each: load and store requests, level, held until `data_resp`.
- `data_mbe` in `DATA_WIDTH/8`: store byte enables.
- `data_addr` in `ADDR_WIDTH`: load/store address.
- `data_wdata` in `DATA_WIDTH`: store data.
- `data_rdata` out `DATA_WIDTH`: registered load data, valid while `data_resp` is high.
- `data_resp` out 1: one-cycle load/store-complete pulse.
- `mem_read`, `mem_write` out 1 each: memory strobes, held until `mem_resp`.
- `mem_byte_enable` out `DATA_WIDTH/8`: memory byte enables.
- `mem_address` out `ADDR_WIDTH`: memory address.
- `mem_wdata` out `DATA_WIDTH`: memory write data.
- `mem_rdata` in `DATA_WIDTH`: memory read data, valid with `mem_resp`.
- `mem_resp` in 1: memory completion, asserted for one or more cycles.
- `err` out 1: sticky error flag; set on timeout or on an illegal request, cleared only by `rst`.

## Operation
The FSM has five states: IDLE, INST_BUSY, DATA_BUSY, RESPOND, GAP.

- **IDLE**
  - Samples requests.
  - Data has priority over instruction, because the data access belongs to the older instruction.
  - On a request, latches address, wdata, byte enables and direction into `req_*` registers, then goes to DATA_BUSY or INST_BUSY.
  - With no request, stays in IDLE.
- **INST_BUSY / DATA_BUSY**
  - Drive the memory port from the `req_*` registers only; CPU inputs may change without effect.
  - Instruction fetches drive `mem_read=1` with `mem_byte_enable` all ones.
  - On the first cycle with `mem_resp=1`: latch `mem_rdata` into `inst_rdata`/`data_rdata` (the old value is kept for a store), drop the strobes, go to RESPOND.
- **RESPOND**
  - Asserts exactly one of `inst_resp`/`data_resp` for one cycle, then goes to GAP.
- **GAP**
  - A one-cycle guard during which no request is sampled, so the requester can deassert. Next state is IDLE.
- **Watchdog**
  - A counter clears on entry to a BUSY state and increments each BUSY cycle.
  - When it reaches `MAX_WAIT - 1` with no `mem_resp`: drop the strobes, load rdata with 0, set `err`, go to RESPOND.
- **Illegal request**
  - `data_read` and `data_write` both high in IDLE: treat as a write and set `err`.
- **Stray responses**
  - `mem_resp` in IDLE, RESPOND or GAP is ignored.
- **Reset values**
  - FSM state IDLE.
  - All outputs 0, including both rdata registers, `err` and every `mem_*` output.
  - Watchdog counter 0.
- **Reset mid-transaction**
  - The transaction is abandoned and no resp is issued.

## Timing
- Request high in IDLE at cycle 0 → `mem_read`/`mem_write` high from cycle 1.
- `mem_resp` at cycle k (k ≥ 1) → strobes low at k+1, resp pulse at k+1, GAP at k+2, IDLE at k+3.
- Minimum request-to-resp latency is 2 cycles. Minimum back-to-back issue spacing is 4 cycles.
- Both requests pending at cycle 0 → data served first; fetch issued 3 cycles after `data_resp`.
- Memory outputs are registered (driven only from state and `req_*`); there is no combinational path from CPU inputs to `mem_*`.
- Timeout resp occurs at cycle `MAX_WAIT + 1` after issue.

## Structure
- The shared package `mem_arbiter_pkg` holds:
  - the state enum (`IDLE`, `INST_BUSY`, `DATA_BUSY`, `RESPOND`, `GAP`);
  - the word/address typedefs;
  - a `req_t` struct (address, wdata, mbe, is_write, is_inst).
- The watchdog is a natural sub-module, `mem_watchdog`: inputs clear and enable, output `expired`, parameterised by `MAX_WAIT`.

## Test plan
- Fetch with `inst_addr=0x60`, `mem_resp` at k=3, `mem_rdata=0x00A00093` → `mem_read` high cycles 1–3, `mem_address=0x60`, `inst_resp` at cycle 4 with `inst_rdata=0x00A00093`.
- `data_write` with `addr=0x100`, `wdata=0xDEADBEEF`, `mbe=4'b0011` simultaneous with `inst_read` → store issued first with those values; `data_resp` one cycle after `mem_resp`; fetch issued 3 cycles later.
- Change `data_addr` during DATA_BUSY → `mem_address` stays at the latched value.
- Withhold `mem_resp` with `MAX_WAIT=8` → resp with rdata 0 at cycle 9; `err` stays high until `rst`.
- Assert `rst` during INST_BUSY, then `mem_resp` one cycle later → no `inst_resp`; all outputs 0; FSM in IDLE.
- `data_read` and `data_write` both high → `mem_write=1`, `err=1`.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the CPU-to-memory arbiter: FSM states, bus word types and
// the latched request payload.
package mem_arbiter_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned BE_W   = DATA_W / 8;

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [DATA_W-1:0] word_t;
   typedef logic [BE_W-1:0]   be_t;

   typedef enum logic [2:0] {
      IDLE,
      INST_BUSY,
      DATA_BUSY,
      RESPOND,
      GAP
   } state_e;

   // Transaction captured in IDLE and replayed onto the memory port until done
   typedef struct packed {
      addr_t addr;
      word_t wdata;
      be_t   mbe;
      logic  is_write;
      logic  is_inst;
   } req_t;

endpackage

// File: rtl/mem_watchdog.sv
// Busy-cycle counter that flags a memory transaction that has waited too long.
// expired_o is registered and rises in the cycle the count reaches MAX_WAIT-1.
// MAX_WAIT must be at least 2.
module mem_watchdog #(
   parameter int unsigned MAX_WAIT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             expired_q, expired_d;

   // Next count; expiry is anticipated one cycle early so the flag is a flop
   always_comb begin
      cnt_d     = cnt_q;
      expired_d = 1'b0;
      if (clear_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d     = cnt_q + CNT_W'(1);
         expired_d = (cnt_q == CNT_W'(MAX_WAIT - 2));
      end
   end

   // Counter and flag registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         expired_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         expired_q <= expired_d;
      end
   end

   assign expired_o = expired_q;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetches and data loads/stores onto one memory port.
// Data wins over instruction; each transaction is held stable until mem_resp
// (or watchdog timeout) and answered with a one-cycle resp pulse.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = ADDR_W,
   parameter int unsigned DATA_WIDTH = DATA_W,
   parameter int unsigned MAX_WAIT   = 255
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    inst_read,
   input  logic [ADDR_WIDTH-1:0]   inst_addr,
   output logic [DATA_WIDTH-1:0]   inst_rdata,
   output logic                    inst_resp,
   input  logic                    data_read,
   input  logic                    data_write,
   input  logic [DATA_WIDTH/8-1:0] data_mbe,
   input  logic [ADDR_WIDTH-1:0]   data_addr,
   input  logic [DATA_WIDTH-1:0]   data_wdata,
   output logic [DATA_WIDTH-1:0]   data_rdata,
   output logic                    data_resp,
   output logic                    mem_read,
   output logic                    mem_write,
   output logic [DATA_WIDTH/8-1:0] mem_byte_enable,
   output logic [ADDR_WIDTH-1:0]   mem_address,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   input  logic [DATA_WIDTH-1:0]   mem_rdata,
   input  logic                    mem_resp,
   output logic                    err
);

   localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

   state_e                state_q, state_d;
   req_t                  req_q, req_d;
   logic                  mem_read_q, mem_read_d;
   logic                  mem_write_q, mem_write_d;
   logic [DATA_WIDTH-1:0] inst_rdata_q, inst_rdata_d;
   logic [DATA_WIDTH-1:0] data_rdata_q, data_rdata_d;
   logic                  inst_resp_q, inst_resp_d;
   logic                  data_resp_q, data_resp_d;
   logic                  err_q, err_d;
   logic                  wd_clear, wd_en, wd_expired;

   mem_watchdog #(
      .MAX_WAIT (MAX_WAIT)
   ) u_watchdog (
      .clk       (clk),
      .rst       (rst),
      .clear_i   (wd_clear),
      .en_i      (wd_en),
      .expired_o (wd_expired)
   );

   // Next-state, request capture and registered-output logic
   always_comb begin
      state_d      = state_q;
      req_d        = req_q;
      mem_read_d   = mem_read_q;
      mem_write_d  = mem_write_q;
      inst_rdata_d = inst_rdata_q;
      data_rdata_d = data_rdata_q;
      inst_resp_d  = 1'b0;
      data_resp_d  = 1'b0;
      err_d        = err_q;
      wd_clear     = 1'b0;
      wd_en        = 1'b0;

      case (state_q)
         IDLE: begin
            wd_clear = 1'b1;
            if (data_read || data_write) begin
               // Read+write together is illegal; it is carried out as a store
               req_d.addr     = ADDR_W'(data_addr);
               req_d.wdata    = DATA_W'(data_wdata);
               req_d.mbe      = BE_W'(data_mbe);
               req_d.is_write = data_write;
               req_d.is_inst  = 1'b0;
               mem_write_d    = data_write;
               mem_read_d     = !data_write;
               if (data_read && data_write) begin
                  err_d = 1'b1;
               end
               state_d = DATA_BUSY;
            end else if (inst_read) begin
               req_d.addr     = ADDR_W'(inst_addr);
               req_d.wdata    = '0;
               req_d.mbe      = '1;
               req_d.is_write = 1'b0;
               req_d.is_inst  = 1'b1;
               mem_read_d     = 1'b1;
               state_d        = INST_BUSY;
            end
         end

         INST_BUSY, DATA_BUSY: begin
            wd_en = 1'b1;
            if (mem_resp) begin
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
               if (req_q.is_inst) begin
                  inst_rdata_d = mem_rdata;
               end else if (!req_q.is_write) begin
                  data_rdata_d = mem_rdata;
               end
               inst_resp_d = req_q.is_inst;
               data_resp_d = !req_q.is_inst;
               state_d     = RESPOND;
            end else if (wd_expired) begin
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
               if (req_q.is_inst) begin
                  inst_rdata_d = '0;
               end else begin
                  data_rdata_d = '0;
               end
               inst_resp_d = req_q.is_inst;
               data_resp_d = !req_q.is_inst;
               err_d       = 1'b1;
               state_d     = RESPOND;
            end
         end

         RESPOND: state_d = GAP;

         GAP: state_d = IDLE;

         default: state_d = IDLE;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         req_q        <= '0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         inst_rdata_q <= '0;
         data_rdata_q <= '0;
         inst_resp_q  <= 1'b0;
         data_resp_q  <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         req_q        <= req_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         inst_rdata_q <= inst_rdata_d;
         data_rdata_q <= data_rdata_d;
         inst_resp_q  <= inst_resp_d;
         data_resp_q  <= data_resp_d;
         err_q        <= err_d;
      end
   end

   assign inst_rdata      = inst_rdata_q;
   assign inst_resp       = inst_resp_q;
   assign data_rdata      = data_rdata_q;
   assign data_resp       = data_resp_q;
   assign mem_read        = mem_read_q;
   assign mem_write       = mem_write_q;
   assign mem_byte_enable = BE_WIDTH'(req_q.mbe);
   assign mem_address     = ADDR_WIDTH'(req_q.addr);
   assign mem_wdata       = DATA_WIDTH'(req_q.wdata);
   assign err             = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, store/fetch priority, input
// stability, minimum-latency load, timeout, reset mid-transaction, illegal op.
module tb_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        inst_read;
   logic [31:0] inst_addr;
   logic [31:0] inst_rdata;
   logic        inst_resp;
   logic        data_read;
   logic        data_write;
   logic [3:0]  data_mbe;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic [31:0] data_rdata;
   logic        data_resp;
   logic        mem_read;
   logic        mem_write;
   logic [3:0]  mem_byte_enable;
   logic [31:0] mem_address;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_resp;
   logic        err;

   int checks;
   int failures;

   mem_arbiter #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .MAX_WAIT   (8)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .inst_read       (inst_read),
      .inst_addr       (inst_addr),
      .inst_rdata      (inst_rdata),
      .inst_resp       (inst_resp),
      .data_read       (data_read),
      .data_write      (data_write),
      .data_mbe        (data_mbe),
      .data_addr       (data_addr),
      .data_wdata      (data_wdata),
      .data_rdata      (data_rdata),
      .data_resp       (data_resp),
      .mem_read        (mem_read),
      .mem_write       (mem_write),
      .mem_byte_enable (mem_byte_enable),
      .mem_address     (mem_address),
      .mem_wdata       (mem_wdata),
      .mem_rdata       (mem_rdata),
      .mem_resp        (mem_resp),
      .err             (err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are sampled and inputs driven at the negedge
   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      checks     = 0;
      failures   = 0;
      rst        = 1'b1;
      inst_read  = 1'b0;
      inst_addr  = '0;
      data_read  = 1'b0;
      data_write = 1'b0;
      data_mbe   = '0;
      data_addr  = '0;
      data_wdata = '0;
      mem_rdata  = '0;
      mem_resp   = 1'b0;

      // Reset state
      step(); step();
      chk("rst_mem_read",   64'(mem_read),   64'(0));
      chk("rst_mem_write",  64'(mem_write),  64'(0));
      chk("rst_mem_addr",   64'(mem_address), 64'(0));
      chk("rst_mem_be",     64'(mem_byte_enable), 64'(0));
      chk("rst_inst_rdata", 64'(inst_rdata), 64'(0));
      chk("rst_data_rdata", 64'(data_rdata), 64'(0));
      chk("rst_resp",       64'({inst_resp, data_resp}), 64'(0));
      chk("rst_err",        64'(err),        64'(0));
      rst = 1'b0;
      step();

      // Fetch 0x60, mem_resp at k=3
      inst_read = 1'b1;
      inst_addr = 32'h60;
      step();                                   // cycle 1
      chk("f_mem_read_c1", 64'(mem_read), 64'(1));
      chk("f_mem_write_c1", 64'(mem_write), 64'(0));
      chk("f_mem_addr", 64'(mem_address), 64'h60);
      chk("f_mem_be", 64'(mem_byte_enable), 64'hF);
      step();                                   // cycle 2
      step();                                   // cycle 3
      chk("f_mem_read_c3", 64'(mem_read), 64'(1));
      chk("f_no_resp_c3", 64'(inst_resp), 64'(0));
      mem_resp  = 1'b1;
      mem_rdata = 32'h00A00093;
      step();                                   // cycle 4
      chk("f_inst_resp", 64'(inst_resp), 64'(1));
      chk("f_data_resp", 64'(data_resp), 64'(0));
      chk("f_inst_rdata", 64'(inst_rdata), 64'h00A00093);
      chk("f_mem_read_c4", 64'(mem_read), 64'(0));
      inst_read = 1'b0;
      mem_resp  = 1'b0;
      step();                                   // cycle 5 (GAP)
      chk("f_resp_pulse", 64'(inst_resp), 64'(0));
      step();                                   // cycle 6 (IDLE)

      // Store 0x100 competing with a fetch; data goes first
      data_write = 1'b1;
      data_addr  = 32'h100;
      data_wdata = 32'hDEADBEEF;
      data_mbe   = 4'b0011;
      inst_read  = 1'b1;
      inst_addr  = 32'h200;
      step();                                   // cycle 1
      chk("s_mem_write", 64'(mem_write), 64'(1));
      chk("s_mem_read", 64'(mem_read), 64'(0));
      chk("s_mem_addr", 64'(mem_address), 64'h100);
      chk("s_mem_wdata", 64'(mem_wdata), 64'hDEADBEEF);
      chk("s_mem_be", 64'(mem_byte_enable), 64'h3);
      data_addr  = 32'h444;
      data_wdata = 32'h11111111;
      step();                                   // cycle 2
      chk("s_addr_stable", 64'(mem_address), 64'h100);
      chk("s_wdata_stable", 64'(mem_wdata), 64'hDEADBEEF);
      mem_resp  = 1'b1;
      mem_rdata = 32'h99999999;
      step();                                   // cycle 3
      chk("s_data_resp", 64'(data_resp), 64'(1));
      chk("s_inst_resp", 64'(inst_resp), 64'(0));
      chk("s_strobe_low", 64'(mem_write), 64'(0));
      chk("s_rdata_kept", 64'(data_rdata), 64'(0));
      data_write = 1'b0;
      step();                                   // cycle 4, stray mem_resp seen in RESPOND
      chk("s_gap_no_resp", 64'({inst_resp, data_resp}), 64'(0));
      chk("s_gap_no_strobe", 64'({mem_read, mem_write}), 64'(0));
      mem_resp = 1'b0;
      step();                                   // cycle 5 (IDLE)
      chk("s_idle_no_strobe", 64'(mem_read), 64'(0));
      step();                                   // cycle 6: fetch issued
      chk("s_fetch_issue", 64'(mem_read), 64'(1));
      chk("s_fetch_addr", 64'(mem_address), 64'h200);
      mem_resp  = 1'b1;
      mem_rdata = 32'h12345678;
      step();
      chk("s_fetch_resp", 64'(inst_resp), 64'(1));
      chk("s_fetch_rdata", 64'(inst_rdata), 64'h12345678);
      chk("s_err_clear", 64'(err), 64'(0));
      inst_read = 1'b0;
      mem_resp  = 1'b0;
      step(); step();

      // Load with minimum latency
      data_read = 1'b1;
      data_addr = 32'h300;
      data_mbe  = 4'hF;
      step();                                   // cycle 1
      chk("l_mem_read", 64'(mem_read), 64'(1));
      chk("l_mem_addr", 64'(mem_address), 64'h300);
      mem_resp  = 1'b1;
      mem_rdata = 32'hCAFEF00D;
      step();                                   // cycle 2
      chk("l_data_resp", 64'(data_resp), 64'(1));
      chk("l_data_rdata", 64'(data_rdata), 64'hCAFEF00D);
      data_read = 1'b0;
      mem_resp  = 1'b0;
      step(); step();

      // Timeout: MAX_WAIT=8, no mem_resp
      inst_read = 1'b1;
      inst_addr = 32'h80;
      step();                                   // cycle 1
      chk("t_mem_read_c1", 64'(mem_read), 64'(1));
      for (int i = 0; i < 7; i++) step();       // cycle 8
      chk("t_mem_read_c8", 64'(mem_read), 64'(1));
      chk("t_no_resp_c8", 64'(inst_resp), 64'(0));
      chk("t_no_err_c8", 64'(err), 64'(0));
      step();                                   // cycle 9
      chk("t_inst_resp", 64'(inst_resp), 64'(1));
      chk("t_rdata_zero", 64'(inst_rdata), 64'(0));
      chk("t_err_set", 64'(err), 64'(1));
      chk("t_strobe_low", 64'(mem_read), 64'(0));
      inst_read = 1'b0;
      step(); step(); step();
      chk("t_err_sticky", 64'(err), 64'(1));

      // Reset during INST_BUSY, memory answers one cycle later
      inst_read = 1'b1;
      inst_addr = 32'h40;
      step();
      chk("r_busy", 64'(mem_read), 64'(1));
      rst = 1'b1;
      step();
      chk("r_mem_read", 64'(mem_read), 64'(0));
      chk("r_mem_addr", 64'(mem_address), 64'(0));
      chk("r_err", 64'(err), 64'(0));
      chk("r_data_rdata", 64'(data_rdata), 64'(0));
      rst       = 1'b0;
      inst_read = 1'b0;
      mem_resp  = 1'b1;
      mem_rdata = 32'h77777777;
      step();
      chk("r_no_resp", 64'({inst_resp, data_resp}), 64'(0));
      chk("r_rdata_zero", 64'(inst_rdata), 64'(0));
      mem_resp = 1'b0;
      step();

      // Illegal: read and write together -> write plus err
      data_read  = 1'b1;
      data_write = 1'b1;
      data_addr  = 32'h10;
      data_wdata = 32'h55;
      data_mbe   = 4'hF;
      step();
      chk("i_mem_write", 64'(mem_write), 64'(1));
      chk("i_mem_read", 64'(mem_read), 64'(0));
      chk("i_err", 64'(err), 64'(1));
      mem_resp = 1'b1;
      step();
      chk("i_data_resp", 64'(data_resp), 64'(1));
      data_read  = 1'b0;
      data_write = 1'b0;
      mem_resp   = 1'b0;
      step(); step();
      chk("i_err_sticky", 64'(err), 64'(1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
